// File: rtl/stream_demux_router.sv
// stream_demux_router: 1-to-NUM_CH valid/ready demultiplexer with a 2-entry FIFO
// per output channel. Words whose select is outside the channel range are
// discarded and counted in a saturating drop counter.
module stream_demux_router #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic                      in_ready,
    output logic [NUM_CH-1:0]         out_valid,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned CNT_W = 2;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              in_range;
    logic              sel_full;
    logic              drop;

    // Decode the select: in range or not, and whether the addressed channel is full
    always_comb begin
        in_range = 1'b0;
        sel_full = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (in_sel == SEL_W'(i)) begin
                in_range = 1'b1;
                sel_full = full[i];
            end
        end
    end

    // Ready depends only on the select and registered occupancy, never on out_ready
    assign in_ready = !sel_full;
    assign drop     = in_valid && !in_range;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] slot0;
        logic [WIDTH-1:0] slot1;
        logic             rp;
        logic             wp;
        logic [CNT_W-1:0] cnt;

        assign push[g] = in_valid && in_ready && (in_sel == SEL_W'(g));
        assign pop[g]  = out_valid[g] && out_ready[g];

        // Per-channel FIFO storage, pointers and occupancy
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot0 <= '0;
                slot1 <= '0;
                rp    <= 1'b0;
                wp    <= 1'b0;
                cnt   <= '0;
            end else begin
                if (push[g]) begin
                    if (wp) slot1 <= in_data;
                    else    slot0 <= in_data;
                    wp <= ~wp;
                end
                if (pop[g]) begin
                    rp <= ~rp;
                end
                if (push[g] && !pop[g]) begin
                    cnt <= cnt + CNT_W'(1);
                end else if (!push[g] && pop[g]) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end

        assign full[g]                   = (cnt == CNT_W'(2));
        assign out_valid[g]              = (cnt != '0);
        assign out_data[g*WIDTH +: WIDTH] = rp ? slot1 : slot0;
    end

    // Saturating count of discarded out-of-range words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_stream_demux_router.sv
// tb_stream_demux_router: directed stimulus with a per-channel scoreboard for the
// 4-channel instance and a drop-counter model for a 3-channel instance.
module tb_stream_demux_router;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_ready;
    logic [7:0]  drop_cnt;

    logic        in_valid3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic        in_ready3;
    logic [2:0]  out_valid3;
    logic [23:0] out_data3;
    logic [2:0]  out_ready3;
    logic [7:0]  drop_cnt3;

    int total = 0;
    int bad   = 0;

    logic [7:0] q [4][$];
    int         exp_drop  = 0;
    int         exp_drop3 = 0;

    stream_demux_router #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    stream_demux_router #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_data(in_data3), .in_sel(in_sel3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
        .drop_cnt(drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 4-channel instance, sampled mid-cycle
    always @(negedge clk) begin
        logic exp_rdy;
        logic ev;
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            exp_drop = 0;
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", out_data, 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        end else begin
            exp_rdy = (q[in_sel].size() != 2);
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            for (int i = 0; i < 4; i++) begin
                ev = (q[i].size() != 0);
                check($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(ev));
                if (ev) begin
                    check($sformatf("out_data%0d", i), 32'(out_data[i*8 +: 8]), 32'(q[i][0]));
                    if (out_ready[i]) void'(q[i].pop_front());
                end
            end
            if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'h0;
        in_valid3 = 1'b0; in_data3 = 8'h00; in_sel3 = 2'd0; out_ready3 = 3'h0;
        step(); step();
        rst = 1'b0;
        step();

        // One word to each channel, all consumers ready
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = 8'(8'h10 + i);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Stalled channel 2 fills at two words; other selects stay ready
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2;
        in_data = 8'hA0; step();
        in_data = 8'hA1; step();
        in_data = 8'hA2;
        @(negedge clk);
        check("ch2_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_sel = 2'd1;
        #1;
        check("sel1_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 4'hF;
        step(); step(); step();

        // Sustained push+pop on channel 0 with one word resident
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h30;
        step();
        for (int i = 1; i <= 10; i++) begin
            in_data = 8'(8'h30 + i);
            @(negedge clk);
            check("ch0_stream_valid", 32'(out_valid[0]), 32'd1);
            check("ch0_stream_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step(); step();

        // Out-of-range select on the 3-channel instance saturates the drop counter
        in_valid3 = 1'b1; in_sel3 = 2'd3; out_ready3 = 3'h7;
        for (int i = 0; i < 300; i++) begin
            in_data3 = 8'(i);
            @(negedge clk);
            check("drop_ready3", 32'(in_ready3), 32'd1);
            check("drop_valid3", 32'(out_valid3), 32'd0);
            check("drop_cnt3", 32'(drop_cnt3), 32'(exp_drop3));
            if (exp_drop3 < 255) exp_drop3++;
            step();
        end
        in_valid3 = 1'b0;
        step();
        check("drop_cnt3_sat", 32'(drop_cnt3), 32'd255);

        // Fill channels 0 and 1, then reset asynchronously mid-cycle
        out_ready = 4'h0;
        in_valid = 1'b1;
        in_sel = 2'd0; in_data = 8'h40; step();
        in_data = 8'h41; step();
        in_sel = 2'd1; in_data = 8'h42; step();
        in_data = 8'h43; step();
        in_valid = 1'b0;
        @(negedge clk);
        check("prefill_valid", 32'(out_valid), 32'h3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_drop3", 32'(drop_cnt3), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        exp_drop3 = 0;
        step();
        rst = 1'b0;
        step();
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h55;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("post_rst_drop3", 32'(drop_cnt3), 32'd0);

        // Channel 3 stalled with two words while channels 0..2 keep streaming
        out_ready = 4'b0111;
        in_valid = 1'b1; in_sel = 2'd3;
        in_data = 8'hC0; step();
        in_data = 8'hC1; step();
        for (int i = 0; i < 50; i++) begin
            in_sel = 2'(i % 3); in_data = 8'(8'h60 + i);
            @(negedge clk);
            check("stall_ready", 32'(in_ready), 32'd1);
            check("ch3_hold_valid", 32'(out_valid[3]), 32'd1);
            check("ch3_hold_data", 32'(out_data[31:24]), 32'hC0);
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'hF;
        step(); step(); step(); step();
        @(negedge clk);
        check("final_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
